// File: rtl/video_scanout.sv
// Framebuffer scanout engine: fetches SDRAM words into a FIFO and expands them to
// 24-bit RGB two cycles behind the raster timing, flagging FIFO underflow.
package video_scanout_pkg;
  typedef struct packed {
    logic active;
    logic vsync;
  } VGA_Timing;
endpackage

module video_scanout
  import video_scanout_pkg::*;
#(
  parameter int          H_ACTIVE      = 640,
  parameter int          V_ACTIVE      = 480,
  parameter int          PIX_FMT       = 0,
  parameter int          STRIDE_WORDS  = 1024,
  parameter int          FIFO_DEPTH    = 64,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [23:0] fb_base_i,
  output logic        sdram_rd,
  input  logic        sdram_rdy,
  output logic        sdram_ack,
  output logic [23:0] sdram_addr_x16,
  input  logic [15:0] sdram_rdata,
  input  VGA_Timing   timing_i,
  output VGA_Timing   timing_o,
  output logic [23:0] rgb_o,
  output logic        underflow_o
);
  localparam int WPP = (PIX_FMT != 0) ? 2 : 1;
  localparam int WPL = H_ACTIVE * WPP;
  localparam int WW  = $clog2(WPL) + 1;
  localparam int LW  = $clog2(V_ACTIVE) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [WW-1:0] WPL_M1 = WW'(WPL - 1);
  localparam logic [LW-1:0] V_M1   = LW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] FD     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] NPOP   = CW'(WPP);

  typedef enum logic [1:0] {F_WAIT_VS, F_FETCH, F_DONE} frame_st_e;
  typedef enum logic [1:0] {B_IDLE, B_REQ, B_ACK} bus_st_e;

  frame_st_e       frame_st;
  bus_st_e         bus_st;
  logic            vs_q, en_q, discard_q;
  logic            frame_start, push, pop, pix_req, avail;
  logic [23:0]     line_start;
  logic [WW-1:0]   word;
  logic [LW-1:0]   line;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]   fifo_count;
  VGA_Timing       t_d1;
  logic            s1_on, s1_uf;
  logic [15:0]     s1_w0;
  logic [7:0]      s1_b;

  assign frame_start = timing_i.vsync & ~vs_q;
  // A word that arrives after a new frame has started belongs to the old frame.
  assign push    = (bus_st == B_REQ) & sdram_rdy & ~discard_q & ~frame_start;
  assign pix_req = timing_i.active & en_q;
  assign avail   = fifo_count >= NPOP;
  assign pop     = pix_req & avail;
  assign rd_nxt  = rd_ptr + 1'b1;

  function automatic logic [23:0] rgb565(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_st   <= F_WAIT_VS;
      vs_q       <= 1'b0;
      en_q       <= 1'b0;
      line_start <= '0;
      word       <= '0;
      line       <= '0;
    end else begin
      vs_q <= timing_i.vsync;
      if (frame_start) begin
        en_q       <= enable_i;
        line_start <= fb_base_i;
        word       <= '0;
        line       <= '0;
        frame_st   <= enable_i ? F_FETCH : F_WAIT_VS;
      end else begin
        case (frame_st)
          F_FETCH: if (push) begin
            if (word == WPL_M1) begin
              word       <= '0;
              line_start <= line_start + 24'(STRIDE_WORDS);
              if (line == V_M1) frame_st <= F_DONE;
              else              line     <= line + 1'b1;
            end else begin
              word <= word + 1'b1;
            end
          end
          F_DONE:  frame_st <= F_WAIT_VS;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_st         <= B_IDLE;
      sdram_rd       <= 1'b0;
      sdram_ack      <= 1'b0;
      sdram_addr_x16 <= '0;
      discard_q      <= 1'b0;
    end else begin
      case (bus_st)
        B_IDLE: if (frame_st == F_FETCH && !frame_start && fifo_count < FD) begin
          bus_st         <= B_REQ;
          sdram_rd       <= 1'b1;
          sdram_addr_x16 <= line_start + 24'(word);
        end
        B_REQ: begin
          if (frame_start) discard_q <= 1'b1;
          if (sdram_rdy) begin
            bus_st    <= B_ACK;
            sdram_rd  <= 1'b0;
            sdram_ack <= 1'b1;
          end
        end
        B_ACK: begin
          bus_st    <= B_IDLE;
          sdram_ack <= 1'b0;
          discard_q <= 1'b0;
        end
        default: bus_st <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= sdram_rdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + AW'(WPP);
      fifo_count <= fifo_count + CW'(push) - (pop ? NPOP : CW'(0));
    end
  end

  // Stage 1 pops/flags, stage 2 formats; timing rides the same two registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      t_d1        <= '0;
      s1_on       <= 1'b0;
      s1_uf       <= 1'b0;
      s1_w0       <= '0;
      s1_b        <= '0;
      timing_o    <= '0;
      rgb_o       <= '0;
      underflow_o <= 1'b0;
    end else begin
      t_d1     <= timing_i;
      s1_on    <= pop;
      s1_uf    <= pix_req & ~avail;
      s1_w0    <= mem[rd_ptr];
      s1_b     <= mem[rd_nxt][7:0];
      timing_o <= t_d1;
      if (s1_uf)      rgb_o <= UNDERFLOW_RGB;
      else if (s1_on) rgb_o <= (PIX_FMT != 0) ? {s1_w0, s1_b} : rgb565(s1_w0);
      else            rgb_o <= '0;
      if (frame_start) underflow_o <= 1'b0;
      else if (s1_uf)  underflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_video_scanout.sv
// Scoreboard bench: two scanout instances (RGB565 and RGB888) on a small raster
// with a one-cycle SDRAM responder whose ready can be withheld.
module tb_video_scanout;
  import video_scanout_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [1:0]            en, rd, ack, uf, rdy_en;
  logic [1:0]            rdy = '0;
  logic [1:0][23:0]      base, addr, rgb;
  logic [1:0][15:0]      rdata = '0;
  VGA_Timing [1:0]       tin, tout;
  logic [15:0]           mem [2][512];
  logic [23:0]           log_a[$], log_b[$];
  logic [23:0]           exp_a[$], exp_b[$];
  int                    n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  video_scanout #(.H_ACTIVE(4), .V_ACTIVE(2), .PIX_FMT(0), .STRIDE_WORDS(8),
                  .FIFO_DEPTH(4), .UNDERFLOW_RGB(24'hFF00FF)) u_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .fb_base_i(base[0]),
    .sdram_rd(rd[0]), .sdram_rdy(rdy[0]), .sdram_ack(ack[0]),
    .sdram_addr_x16(addr[0]), .sdram_rdata(rdata[0]),
    .timing_i(tin[0]), .timing_o(tout[0]), .rgb_o(rgb[0]), .underflow_o(uf[0]));

  video_scanout #(.H_ACTIVE(4), .V_ACTIVE(2), .PIX_FMT(1), .STRIDE_WORDS(8),
                  .FIFO_DEPTH(4), .UNDERFLOW_RGB(24'hFF00FF)) u_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .fb_base_i(base[1]),
    .sdram_rd(rd[1]), .sdram_rdy(rdy[1]), .sdram_ack(ack[1]),
    .sdram_addr_x16(addr[1]), .sdram_rdata(rdata[1]),
    .timing_i(tin[1]), .timing_o(tout[1]), .rgb_o(rgb[1]), .underflow_o(uf[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp565(input logic [15:0] w);
    logic [7:0] r, g, b;
    r = {w[15:11], 3'b000} | 8'(w[15:11] >> 2);
    g = {w[10:5], 2'b00}   | 8'(w[10:5] >> 4);
    b = {w[4:0], 3'b000}   | 8'(w[4:0] >> 2);
    return {r, g, b};
  endfunction

  // SDRAM responder: ready one cycle after a request is seen, data from mem.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd[i] && rdy_en[i] && !rdy[i]) begin
        rdy[i]   = 1'b1;
        rdata[i] = mem[i][addr[i][8:0]];
        if (i == 0) log_a.push_back(addr[i]);
        else        log_b.push_back(addr[i]);
      end else begin
        rdy[i]   = 1'b0;
        rdata[i] = 16'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tout[0].active) begin
        if (exp_a.size() == 0) chk("a_px_extra", 32'(rgb[0]), 32'hFFFF_FFFF);
        else                   chk("a_px", 32'(rgb[0]), 32'(exp_a.pop_front()));
      end
      if (tout[1].active) begin
        if (exp_b.size() == 0) chk("b_px_extra", 32'(rgb[1]), 32'hFFFF_FFFF);
        else                   chk("b_px", 32'(rgb[1]), 32'(exp_b.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs(input int d, input logic e, input logic [23:0] b);
    base[d] = b;
    en[d] = e;
    tin[d].vsync = 1'b1;
    @(negedge clk);
    tin[d].vsync = 1'b0;
  endtask

  task automatic px(input int d, input logic [23:0] e);
    tin[d].active = 1'b1;
    if (d == 0) exp_a.push_back(e);
    else        exp_b.push_back(e);
    @(negedge clk);
    tin[d].active = 1'b0;
  endtask

  task automatic wait_log(input int d, input int n, input int budget, input string tag);
    int c = 0;
    while (((d == 0) ? log_a.size() : log_b.size()) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'((d == 0) ? log_a.size() : log_b.size()), 32'(n));
  endtask

  initial begin
    int m;
    en = '0; base = '0; tin = '0; rdy_en = '0;
    for (int i = 0; i < 512; i++) begin
      mem[0][i] = 16'(i * 37 + 'h1357);
      mem[1][i] = 16'(i * 91 + 'h2468);
    end
    mem[0][0] = 16'hFFFF; mem[0][9'h020] = 16'h8421;
    mem[0][9'h100] = 16'hF800; mem[0][9'h101] = 16'h07E0;
    mem[1][0] = 16'h1234; mem[1][1] = 16'h0056; mem[1][2] = 16'hABCD; mem[1][3] = 16'h00EF;

    #1 rst = 1'b1;
    cyc(2);
    chk("rst_rd",   32'(rd[0]),   32'd0);
    chk("rst_ack",  32'(ack[0]),  32'd0);
    chk("rst_addr", 32'(addr[0]), 32'd0);
    chk("rst_rgb",  32'(rgb[0]),  32'd0);
    chk("rst_tout", 32'(tout[0]), 32'd0);
    chk("rst_uf",   32'(uf[0]),   32'd0);
    rst = 1'b0;
    rdy_en[0] = 1'b1;
    cyc(2);

    // Frame 1: RGB565 pixels, stride addressing, stop after the frame's words.
    vs(0, 1'b1, 24'h000100);
    wait_log(0, 4, 60, "a_fill");
    cyc(3);
    chk("a_rd_full", 32'(rd[0]), 32'd0);
    for (int k = 0; k < 4; k++) px(0, exp565(mem[0][9'h100 + k]));
    wait_log(0, 8, 80, "a_fill2");
    cyc(2);
    for (int k = 0; k < 4; k++) px(0, exp565(mem[0][9'h108 + k]));
    cyc(20);
    chk("a_nreads", 32'(log_a.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_a.size(); k++)
      chk("a_addr", 32'(log_a[k]), 32'(24'h100 + (k / 4) * 8 + (k % 4)));
    chk("a_rd_done", 32'(rd[0]), 32'd0);
    chk("a_uf_f1", 32'(uf[0]), 32'd0);

    // Frame 2: ready withheld -> underflow colour and sticky flag.
    rdy_en[0] = 1'b0;
    m = log_a.size();
    vs(0, 1'b1, 24'h000020);
    cyc(3);
    chk("a_rd_stall",   32'(rd[0]),   32'd1);
    chk("a_addr_stall", 32'(addr[0]), 32'h20);
    px(0, 24'hFF00FF);
    px(0, 24'hFF00FF);
    cyc(3);
    chk("a_uf_set", 32'(uf[0]), 32'd1);

    // Frame 3 starts mid-request: old word discarded, fetch restarts at new base.
    vs(0, 1'b1, 24'h000040);
    cyc(1);
    chk("a_uf_clr",  32'(uf[0]), 32'd0);
    chk("a_rd_hold", 32'(rd[0]), 32'd1);
    rdy_en[0] = 1'b1;
    cyc(30);
    chk("a_nreads2", 32'(log_a.size() - m), 32'd5);
    if (log_a.size() >= m + 5) begin
      chk("a_stale_addr", 32'(log_a[m]), 32'h20);
      for (int k = 0; k < 4; k++) chk("a_new_addr", 32'(log_a[m + 1 + k]), 32'(24'h40 + k));
    end
    chk("a_rd_full2", 32'(rd[0]), 32'd0);
    rdy_en[0] = 1'b0;
    for (int k = 0; k < 4; k++) px(0, exp565(mem[0][9'h040 + k]));
    cyc(4);
    chk("a_rd_pre_rst", 32'(rd[0]), 32'd1);

    // Async reset between edges while a request is pending and rgb_o is lit.
    px(0, 24'hFF00FF);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd",   32'(rd[0]),   32'd0);
    chk("arst_ack",  32'(ack[0]),  32'd0);
    chk("arst_addr", 32'(addr[0]), 32'd0);
    chk("arst_rgb",  32'(rgb[0]),  32'd0);
    chk("arst_uf",   32'(uf[0]),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    px(0, 24'h000000);
    vs(0, 1'b1, 24'h000000);
    cyc(2);
    px(0, 24'hFF00FF);
    cyc(4);
    chk("a_uf_post_rst", 32'(uf[0]), 32'd1);

    // RGB888: two words per pixel.
    rdy_en[1] = 1'b1;
    vs(1, 1'b1, 24'h000000);
    wait_log(1, 4, 60, "b_fill");
    cyc(3);
    chk("b_rd_full", 32'(rd[1]), 32'd0);
    px(1, 24'h123456);
    px(1, 24'hABCDEF);
    cyc(20);
    chk("b_nreads", 32'(log_b.size()), 32'd8);
    for (int k = 0; k < 8 && k < log_b.size(); k++) chk("b_addr", 32'(log_b[k]), 32'(k));

    cyc(5);
    chk("a_sb_empty", 32'(exp_a.size()), 32'd0);
    chk("b_sb_empty", 32'(exp_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
